// File: rtl/rx_data_buffer.sv
// Serial receive data buffer.
// Synchronises the receive-side control signals into the CLK domain and shifts
// in bits LSB-first. Completed SIZE-bit frames go into a first-word-fall-through
// FIFO. Sticky flags record dropped words and malformed frames.
module rx_data_buffer #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RXC,
  input  logic                     RXD,
  input  logic                     RXEN,
  input  logic                     RXRDY,
  output logic [SIZE-1:0]          DOUT,
  output logic                     DVALID,
  input  logic                     DREADY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVERRUN,
  output logic                     FRAME_ERR,
  input  logic                     CLR_ERR
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned CntW = $clog2(SIZE + 2);

  localparam logic [CntW-1:0] CntSize = CntW'(SIZE);
  localparam logic [CntW-1:0] CntMax  = CntW'(SIZE + 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

  // Bit order in the synchroniser vectors: 0 RXC, 1 RXD, 2 RXEN, 3 RXRDY.
  logic [3:0] async_in;
  logic [3:0] sync1_q, sync2_q, hist_q;
  logic [1:0] warm_q;
  logic       armed;
  logic [3:0] rise;
  logic       rxc_rise, rxrdy_rise, capture;
  logic       unused_rise;

  logic [SIZE-1:0] sr_q, sr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push;
  logic            frame_err_set;

  logic [SIZE-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            full;
  logic            pop;
  logic            wr_en;
  logic            overrun_set;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;

  assign async_in = {RXRDY, RXEN, RXD, RXC};

  // Two-flop synchronisers, history flops and the post-reset warm-up counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      warm_q  <= '0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      if (warm_q != 2'd3) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

  // Edges are only trusted once the history flop holds a real sample; this stops
  // an input held high across reset release from looking like a fresh rise.
  assign armed      = (warm_q == 2'd3);
  assign rise       = sync2_q & ~hist_q & {4{armed}};
  assign rxc_rise   = rise[0];
  assign rxrdy_rise = rise[3];
  assign capture    = rxc_rise & sync2_q[2];

  // RXD and RXEN are used as levels; their edge terms are intentionally unused.
  assign unused_rise = ^rise[2:1];

  // Shift/count next state: a capture is applied before a same-cycle end of frame.
  always_comb begin
    sr_d          = sr_q;
    cnt_d         = cnt_q;
    push          = 1'b0;
    frame_err_set = 1'b0;
    if (capture) begin
      sr_d = {sync2_q[1], sr_q[SIZE-1:1]};
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    if (rxrdy_rise) begin
      if (cnt_d == CntSize) begin
        push = 1'b1;
      end else begin
        frame_err_set = 1'b1;
      end
      cnt_d = '0;
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign full        = (level_q == LvlFull);
  assign pop         = DVALID & DREADY;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en       = push & (~full | pop);
  assign overrun_set = push & full & ~pop;

  // FIFO pointer and level next state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (wr_en) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // Sticky flags: a set condition wins over a same-cycle clear.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (CLR_ERR) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end
    if (frame_err_set) begin
      frame_err_d = 1'b1;
    end
  end

  // FIFO control state and error flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wptr_q] <= sr_d;
    end
  end

  assign DVALID    = (level_q != '0);
  // Empty FIFO reads as zero so DOUT is clean after reset.
  assign DOUT      = DVALID ? mem_q[rptr_q] : '0;
  assign LEVEL     = level_q;
  assign OVERRUN   = overrun_q;
  assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_rx_data_buffer.sv
// Directed testbench for rx_data_buffer (SIZE=8, DEPTH=4).
module tb_rx_data_buffer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RXC = 1'b0;
  logic       RXD = 1'b0;
  logic       RXEN = 1'b0;
  logic       RXRDY = 1'b0;
  logic [7:0] DOUT;
  logic       DVALID;
  logic       DREADY = 1'b0;
  logic [2:0] LEVEL;
  logic       OVERRUN;
  logic       FRAME_ERR;
  logic       CLR_ERR = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  rx_data_buffer #(
    .SIZE (8),
    .DEPTH(4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RXC      (RXC),
    .RXD      (RXD),
    .RXEN     (RXEN),
    .RXRDY    (RXRDY),
    .DOUT     (DOUT),
    .DVALID   (DVALID),
    .DREADY   (DREADY),
    .LEVEL    (LEVEL),
    .OVERRUN  (OVERRUN),
    .FRAME_ERR(FRAME_ERR),
    .CLR_ERR  (CLR_ERR)
  );

  always #5 CLK = ~CLK;

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    RXD = b;
    tick(3);
    RXC = 1'b1;
    tick(4);
    RXC = 1'b0;
    tick(3);
  endtask

  task automatic end_frame();
    RXRDY = 1'b1;
    tick(4);
    RXRDY = 1'b0;
    tick(3);
  endtask

  task automatic send_frame(input logic [7:0] word, input int nbits);
    RXEN = 1'b1;
    tick(3);
    for (int i = 0; i < nbits; i++) send_bit(word[i]);
    end_frame();
    RXEN = 1'b0;
    tick(2);
  endtask

  task automatic pop_one();
    DREADY = 1'b1;
    tick(1);
    DREADY = 1'b0;
    tick(1);
  endtask

  task automatic clr_pulse();
    CLR_ERR = 1'b1;
    tick(1);
    CLR_ERR = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(5);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (LEVEL !== 3'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", LEVEL); end
    vectors++; if (DVALID !== 1'b0) begin miscompares++; $display("FAIL reset_dvalid: got %b want 0", DVALID); end
    vectors++; if (OVERRUN !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", OVERRUN); end
    vectors++; if (FRAME_ERR !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", FRAME_ERR); end
    vectors++; if (DOUT !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %h want 00", DOUT); end
  endtask

  task automatic test_single_frame();
    send_frame(8'h55, 8);
    vectors++; if (DOUT !== 8'h55) begin miscompares++; $display("FAIL single_dout: got %h want 55", DOUT); end
    vectors++; if (DVALID !== 1'b1) begin miscompares++; $display("FAIL single_dvalid: got %b want 1", DVALID); end
    vectors++; if (LEVEL !== 3'd1) begin miscompares++; $display("FAIL single_level: got %0d want 1", LEVEL); end
    vectors++; if (FRAME_ERR !== 1'b0) begin miscompares++; $display("FAIL single_frame_err: got %b want 0", FRAME_ERR); end
    pop_one();
    vectors++; if (LEVEL !== 3'd0) begin miscompares++; $display("FAIL single_pop_level: got %0d want 0", LEVEL); end
    vectors++; if (DVALID !== 1'b0) begin miscompares++; $display("FAIL single_pop_dvalid: got %b want 0", DVALID); end
    // DREADY while empty must not underflow.
    pop_one();
    vectors++; if (LEVEL !== 3'd0) begin miscompares++; $display("FAIL empty_pop_level: got %0d want 0", LEVEL); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h7F, 7);
    vectors++; if (FRAME_ERR !== 1'b1) begin miscompares++; $display("FAIL ferr_set: got %b want 1", FRAME_ERR); end
    vectors++; if (LEVEL !== 3'd0) begin miscompares++; $display("FAIL ferr_level: got %0d want 0", LEVEL); end
    tick(10);
    vectors++; if (FRAME_ERR !== 1'b1) begin miscompares++; $display("FAIL ferr_sticky: got %b want 1", FRAME_ERR); end
    clr_pulse();
    vectors++; if (FRAME_ERR !== 1'b0) begin miscompares++; $display("FAIL ferr_clear: got %b want 0", FRAME_ERR); end
  endtask

  // Eighth RXC rise coincides with the RXRDY rise; the bit must count.
  task automatic test_same_cycle_capture();
    logic [7:0] w;
    w = 8'h96;
    RXEN = 1'b1;
    tick(3);
    for (int i = 0; i < 7; i++) send_bit(w[i]);
    RXD = w[7];
    tick(3);
    RXC = 1'b1;
    RXRDY = 1'b1;
    tick(4);
    RXC = 1'b0;
    RXRDY = 1'b0;
    tick(3);
    RXEN = 1'b0;
    tick(2);
    vectors++; if (DOUT !== 8'h96) begin miscompares++; $display("FAIL same_cycle_dout: got %h want 96", DOUT); end
    vectors++; if (LEVEL !== 3'd1) begin miscompares++; $display("FAIL same_cycle_level: got %0d want 1", LEVEL); end
    vectors++; if (FRAME_ERR !== 1'b0) begin miscompares++; $display("FAIL same_cycle_ferr: got %b want 0", FRAME_ERR); end
  endtask

  // Entry from the previous test is still queued; reset must drop it and the partial frame.
  task automatic test_reset_midframe();
    RXEN = 1'b1;
    tick(3);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    RXEN = 1'b0;
    do_reset();
    vectors++; if (LEVEL !== 3'd0) begin miscompares++; $display("FAIL rst_mid_level: got %0d want 0", LEVEL); end
    vectors++; if (DOUT !== 8'h00) begin miscompares++; $display("FAIL rst_mid_dout: got %h want 00", DOUT); end
    send_frame(8'hA3, 8);
    vectors++; if (LEVEL !== 3'd1) begin miscompares++; $display("FAIL rst_mid_a3_level: got %0d want 1", LEVEL); end
    vectors++; if (DOUT !== 8'hA3) begin miscompares++; $display("FAIL rst_mid_a3_dout: got %h want a3", DOUT); end
    vectors++; if (FRAME_ERR !== 1'b0) begin miscompares++; $display("FAIL rst_mid_a3_ferr: got %b want 0", FRAME_ERR); end
    pop_one();
  endtask

  task automatic test_rxen_low();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    vectors++; if (LEVEL !== 3'd0) begin miscompares++; $display("FAIL rxen_low_idle_level: got %0d want 0", LEVEL); end
    RXEN = 1'b1;
    tick(3);
    for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b0);
    RXEN = 1'b0;
    tick(3);
    vectors++; if (LEVEL !== 3'd0) begin miscompares++; $display("FAIL rxen_low_nopush: got %0d want 0", LEVEL); end
    // These rises with RXEN low must not shift a 1 in or bump the count past 8.
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    end_frame();
    vectors++; if (LEVEL !== 3'd1) begin miscompares++; $display("FAIL rxen_low_level: got %0d want 1", LEVEL); end
    vectors++; if (DOUT !== 8'h00) begin miscompares++; $display("FAIL rxen_low_dout: got %h want 00", DOUT); end
    vectors++; if (FRAME_ERR !== 1'b0) begin miscompares++; $display("FAIL rxen_low_ferr: got %b want 0", FRAME_ERR); end
    pop_one();
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 8);
    vectors++; if (LEVEL !== 3'd4) begin miscompares++; $display("FAIL ovr_level: got %0d want 4", LEVEL); end
    vectors++; if (OVERRUN !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b want 1", OVERRUN); end
    for (int k = 1; k <= 4; k++) begin
      exp = 8'(k);
      vectors++; if (DOUT !== exp) begin miscompares++; $display("FAIL ovr_pop%0d: got %h want %h", k, DOUT, exp); end
      pop_one();
    end
    vectors++; if (DVALID !== 1'b0) begin miscompares++; $display("FAIL ovr_empty: got %b want 0", DVALID); end
    vectors++; if (OVERRUN !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky: got %b want 1", OVERRUN); end
    clr_pulse();
    vectors++; if (OVERRUN !== 1'b0) begin miscompares++; $display("FAIL ovr_clear: got %b want 0", OVERRUN); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] w;
    logic [7:0] exp;
    for (int k = 0; k < 4; k++) send_frame(8'h11 + 8'(k), 8);
    vectors++; if (LEVEL !== 3'd4) begin miscompares++; $display("FAIL fpp_fill_level: got %0d want 4", LEVEL); end
    w = 8'h15;
    RXEN = 1'b1;
    tick(3);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    // Push lands on the third edge after RXRDY rises; pop on that same edge.
    RXRDY = 1'b1;
    tick(2);
    DREADY = 1'b1;
    tick(1);
    DREADY = 1'b0;
    tick(2);
    RXRDY = 1'b0;
    RXEN = 1'b0;
    tick(3);
    vectors++; if (LEVEL !== 3'd4) begin miscompares++; $display("FAIL fpp_level: got %0d want 4", LEVEL); end
    vectors++; if (OVERRUN !== 1'b0) begin miscompares++; $display("FAIL fpp_overrun: got %b want 0", OVERRUN); end
    for (int k = 0; k < 4; k++) begin
      exp = 8'h12 + 8'(k);
      vectors++; if (DOUT !== exp) begin miscompares++; $display("FAIL fpp_pop%0d: got %h want %h", k, DOUT, exp); end
      pop_one();
    end
    vectors++; if (DVALID !== 1'b0) begin miscompares++; $display("FAIL fpp_empty: got %b want 0", DVALID); end
  endtask

  task automatic test_held_high_reset();
    RXEN = 1'b1;
    RXC = 1'b1;
    RXRDY = 1'b1;
    tick(3);
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(8);
    vectors++; if (FRAME_ERR !== 1'b0) begin miscompares++; $display("FAIL held_ferr: got %b want 0", FRAME_ERR); end
    vectors++; if (LEVEL !== 3'd0) begin miscompares++; $display("FAIL held_level: got %0d want 0", LEVEL); end
    RXC = 1'b0;
    RXRDY = 1'b0;
    tick(3);
    send_frame(8'h5A, 8);
    vectors++; if (LEVEL !== 3'd1) begin miscompares++; $display("FAIL held_frame_level: got %0d want 1", LEVEL); end
    vectors++; if (DOUT !== 8'h5A) begin miscompares++; $display("FAIL held_frame_dout: got %h want 5a", DOUT); end
    vectors++; if (FRAME_ERR !== 1'b0) begin miscompares++; $display("FAIL held_frame_ferr: got %b want 0", FRAME_ERR); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_single_frame();
    test_frame_err();
    test_same_cycle_capture();
    test_reset_midframe();
    test_rxen_low();
    test_overrun();
    test_full_push_pop();
    test_held_high_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_data_buffer.md
RX_DATA_BUFFER -- requirements
Module: rx_data_buffer

Interface
REQ-001 Parameter SIZE, default 8: data bits per frame, range 5..16.
REQ-002 Parameter DEPTH, default 4: FIFO entries, power of two, at least 2.
REQ-003 CLK  in  1  system clock; the only clock; all state changes on rising edge.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 RXC  in  1  receive bit clock, asynchronous to CLK.
REQ-006 RXD  in  1  serial receive data, asynchronous to CLK.
REQ-007 RXEN  in  1  from receive control unit; high while data bits are valid.
REQ-008 RXRDY  in  1  from receive control unit; rising edge marks end of frame.
REQ-009 DOUT  out  SIZE  FIFO head word; first received bit is in DOUT[0].
REQ-010 DVALID  out  1  FIFO non-empty; DOUT is valid.
REQ-011 DREADY  in  1  consumer accepts the head word when DVALID=1.
REQ-012 LEVEL  out  $clog2(DEPTH)+1  number of stored words.
REQ-013 OVERRUN  out  1  sticky flag: a word was dropped because the FIFO was full.
REQ-014 FRAME_ERR  out  1  sticky flag: a frame ended with a bit count other than SIZE.
REQ-015 CLR_ERR  in  1  clears OVERRUN and FRAME_ERR.

Function
REQ-016 The block SHALL pass RXC, RXD, RXEN and RXRDY each through a 2-flop synchroniser plus one history flop.
REQ-017 Edge detect SHALL be sync stage 2 high and history flop low.
REQ-018 The action for a detected edge SHALL occur on the 3rd CLK rising edge after the first edge that samples the input high.
REQ-019 Bit capture: on each synced RXC rise with synced RXEN=1, the shift register SHALL update as sr <= {RXD_sync, sr[SIZE-1:1]}.
REQ-020 On each such capture the bit counter SHALL increment, saturating at SIZE+1.
REQ-021 RXC rises with synced RXEN=0 SHALL be ignored.
REQ-022 End of frame: on a synced RXRDY rise with bit count = SIZE, the block SHALL request a push of sr.
REQ-023 On a synced RXRDY rise with any other bit count, the block SHALL set FRAME_ERR and push nothing.
REQ-024 The bit counter SHALL clear to 0 on every synced RXRDY rise, whether or not a push occurs.
REQ-025 An RXC capture and an RXRDY rise detected in the same cycle SHALL be handled capture first; the captured bit counts toward the frame.
REQ-026 FIFO: circular buffer, write and read pointers wrapping modulo DEPTH.
REQ-027 The FIFO SHALL be first-word-fall-through: DOUT shows the head word combinationally from storage.
REQ-028 DVALID SHALL be 1 exactly when LEVEL != 0.
REQ-029 A pop SHALL occur when DVALID and DREADY are both 1; it advances the read pointer and decrements LEVEL.
REQ-030 DREADY with DVALID=0 SHALL have no effect.
REQ-031 A push with LEVEL < DEPTH SHALL write the word, advance the write pointer and increment LEVEL.
REQ-032 Push and pop in the same cycle SHALL both take effect with LEVEL unchanged, including at LEVEL=DEPTH.
REQ-033 At LEVEL=DEPTH, a push without a simultaneous pop SHALL drop the word, set OVERRUN and leave the stored contents unchanged.
REQ-034 CLR_ERR=1 SHALL clear both flags next cycle.
REQ-035 If CLR_ERR and a set condition occur in the same cycle, set SHALL win.
REQ-036 OVERRUN and FRAME_ERR SHALL hold their value until CLR_ERR or RST.

Reset
REQ-037 RST=1 at a CLK edge SHALL clear all synchroniser and history flops, the shift register, the bit counter and both pointers.
REQ-038 After RST: LEVEL=0, DVALID=0, OVERRUN=0, FRAME_ERR=0, DOUT=0.
REQ-039 RST SHALL dominate all other inputs.
REQ-040 A frame in progress at RST SHALL be discarded; no push from it.
REQ-041 An input held high through reset release SHALL NOT produce an edge.

Verification
REQ-042 One frame, RXEN high, 8 RXC rises with RXD=1,0,1,0,1,0,1,0, then RXRDY rise -> DOUT=8'h55, DVALID=1, LEVEL=1.
REQ-043 RXRDY rise after 7 captured bits -> FRAME_ERR=1, LEVEL unchanged; CLR_ERR pulse -> FRAME_ERR=0.
REQ-044 Five frames 8'h01..8'h05, DREADY=0 -> LEVEL=4, OVERRUN=1; pops yield 01,02,03,04, then DVALID=0.
REQ-045 Full FIFO, push and pop in the same cycle -> LEVEL stays 4, OVERRUN=0, read order preserved.
REQ-046 RST asserted after 4 captured bits, then a clean frame 8'hA3 -> only 8'hA3 is stored, LEVEL=1.
REQ-047 RXC toggling with RXEN=0 -> no bit count change, no push.
